// File: rtl/train_pkg.sv
// rtl/train_pkg.sv - shared types and defaults for the train dispatch checker
package train_pkg;

    localparam int DEFAULT_MAX_CARS = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_BADINPUT = 2'd3
    } err_t;

endpackage

// File: rtl/train_station.sv
// rtl/train_station.sv - siding storage usable as a stack (LIFO) or a ring queue (FIFO)
module train_station #(
    parameter int DEPTH = 10,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_mode,
    input  logic         i_clear,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_head,
    output logic [W-1:0] o_occupancy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [W-1:0]  r_mem [0:DEPTH-1];
    logic [W-1:0]  r_occ;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;

    logic [AW-1:0] w_top_idx;
    logic [AW-1:0] w_push_idx;

    // Stack uses the occupancy as its top pointer; queue uses its own write pointer.
    assign w_top_idx  = AW'(r_occ - 1'b1);
    assign w_push_idx = i_mode ? r_wr_ptr : AW'(r_occ);

    // Head is read straight from storage; an empty station reports 0, which never matches a legal car.
    always_comb begin
        o_head = '0;
        if (r_occ != '0) begin
            o_head = i_mode ? r_mem[r_rd_ptr] : r_mem[w_top_idx];
        end
    end

    assign o_occupancy = r_occ;

    // Storage, occupancy and queue pointers; clear empties the station without wiping entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_occ    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (i_clear) begin
            r_occ    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (i_push) begin
                r_mem[w_push_idx] <= i_data;
                if (i_mode) begin
                    r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
                end
            end
            if (i_pop && i_mode) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (i_pop && !i_push) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

endmodule

// File: rtl/train_dispatch_checker.sv
// rtl/train_dispatch_checker.sv - decides whether a departure order is reachable through a station
module train_dispatch_checker
    import train_pkg::*;
#(
    parameter int MAX_CARS = DEFAULT_MAX_CARS,
    parameter int DEPTH    = MAX_CARS,
    parameter int W        = $clog2(MAX_CARS + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] data,
    input  logic         mode,
    output logic         out_valid,
    output logic         result,
    output logic [1:0]   err_code
);

    localparam int TAW = (MAX_CARS > 1) ? $clog2(MAX_CARS) : 1;
    localparam logic [W-1:0] MAX_W   = W'(MAX_CARS);
    localparam logic [W-1:0] DEPTH_W = W'(DEPTH);

    state_t       r_state;
    logic [W-1:0] r_n;
    logic [W-1:0] r_k;
    logic [W-1:0] r_ptr;
    logic [W-1:0] r_c;
    logic         r_mode;
    logic         r_bad;
    logic         r_all_pushed;
    logic [W-1:0] r_target [0:MAX_CARS-1];
    logic         r_out_valid;
    logic         r_result;
    err_t         r_err;

    logic [W-1:0] w_head;
    logic [W-1:0] w_occ;
    logic [W-1:0] w_tgt;
    logic         w_head_match;
    logic         w_can_push;
    logic         w_run_act;
    logic         w_push;
    logic         w_pop;
    logic         w_clear;

    // Guard the target lookup: ptr reaches N (possibly MAX_CARS) once every car has left.
    assign w_tgt        = (r_ptr < MAX_W) ? r_target[r_ptr[TAW-1:0]] : '0;
    assign w_head_match = (w_occ != '0) && (w_head == w_tgt);
    // all_pushed replaces a c<=N compare so c may wrap harmlessly after the last car.
    assign w_can_push   = !r_all_pushed && (w_occ < DEPTH_W);
    assign w_run_act    = (r_state == ST_RUN) && !r_bad && (r_ptr != r_n);
    assign w_pop        = w_run_act && w_head_match;
    assign w_push       = w_run_act && !w_head_match && w_can_push;
    assign w_clear      = (r_state == ST_LOAD) && !in_valid;

    train_station #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_station (
        .clk         (clk),
        .rst         (rst),
        .i_mode      (r_mode),
        .i_clear     (w_clear),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_data      (r_c),
        .o_head      (w_head),
        .o_occupancy (w_occ)
    );

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign err_code  = r_err;

    // Control FSM: header capture, target load with validation, one station action per RUN cycle, verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_n          <= '0;
            r_k          <= '0;
            r_ptr        <= '0;
            r_c          <= '0;
            r_mode       <= 1'b0;
            r_bad        <= 1'b0;
            r_all_pushed <= 1'b0;
            for (int i = 0; i < MAX_CARS; i++) begin
                r_target[i] <= '0;
            end
            r_out_valid  <= 1'b0;
            r_result     <= 1'b0;
            r_err        <= ERR_OK;
        end else begin
            r_out_valid <= 1'b0;
            r_result    <= 1'b0;
            r_err       <= ERR_OK;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_n     <= data;
                        r_mode  <= mode;
                        r_k     <= '0;
                        r_bad   <= 1'b0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (r_k < MAX_W) begin
                            r_target[r_k[TAW-1:0]] <= data;
                            r_k <= r_k + 1'b1;
                            if ((data == '0) || (data > r_n)) begin
                                r_bad <= 1'b1;
                            end
                        end else begin
                            r_bad <= 1'b1;
                        end
                    end else begin
                        r_bad        <= r_bad | (r_n == '0) | (r_n > MAX_W) | (r_k != r_n);
                        r_ptr        <= '0;
                        r_c          <= W'(1);
                        r_all_pushed <= 1'b0;
                        r_state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_bad) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_err       <= ERR_BADINPUT;
                    end else if (r_ptr == r_n) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= 1'b1;
                    end else if (w_head_match) begin
                        r_ptr <= r_ptr + 1'b1;
                    end else if (w_can_push) begin
                        r_c <= r_c + 1'b1;
                        if (r_c == r_n) begin
                            r_all_pushed <= 1'b1;
                        end
                    end else if (!r_all_pushed) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_err       <= ERR_OVERFLOW;
                    end else begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_err       <= ERR_MISMATCH;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_train_dispatch_checker.sv
// tb/tb_train_dispatch_checker.sv - scoreboard bench over three station depths (10, 2, 4)
module tb_train_dispatch_checker;

    localparam int MAXC = 10;
    localparam int W    = 4;

    typedef int tgt_t [16];

    localparam logic [2:0] V_PASS = 3'b100;
    localparam logic [2:0] V_MIS  = 3'b001;
    localparam logic [2:0] V_OVF  = 3'b010;
    localparam logic [2:0] V_BAD  = 3'b011;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] data = '0;

    logic       ov0, ov2, ov4;
    logic       res0, res2, res4;
    logic [1:0] err0, err2, err4;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] sq [3][$];
    logic       ov [3];
    logic [2:0] vr [3];
    bit         prev_ov [3];

    always #5 clk = ~clk;

    train_dispatch_checker #(.MAX_CARS(MAXC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .mode(mode),
        .out_valid(ov0), .result(res0), .err_code(err0)
    );

    train_dispatch_checker #(.MAX_CARS(MAXC), .DEPTH(2)) dut_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .mode(mode),
        .out_valid(ov2), .result(res2), .err_code(err2)
    );

    train_dispatch_checker #(.MAX_CARS(MAXC), .DEPTH(4)) dut_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data(data), .mode(mode),
        .out_valid(ov4), .result(res4), .err_code(err4)
    );

    assign ov[0] = ov0;
    assign ov[1] = ov2;
    assign ov[2] = ov4;
    assign vr[0] = {res0, err0};
    assign vr[1] = {res2, err2};
    assign vr[2] = {res4, err4};

    // Scoreboard: pop an expected verdict per strobe; outputs must be quiet otherwise.
    always @(negedge clk) begin
        logic [2:0] exp_v;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ov[i]) begin
                if (prev_ov[i]) begin
                    n_errors++;
                    $display("FAIL out_valid_width inst%0d: out_valid high two cycles, required one", i);
                end else if (sq[i].size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_verdict inst%0d: got %b, required no verdict", i, vr[i]);
                end else begin
                    exp_v = sq[i].pop_front();
                    if (vr[i] !== exp_v) begin
                        n_errors++;
                        $display("FAIL verdict inst%0d: got {result,err}=%b, required %b", i, vr[i], exp_v);
                    end
                end
            end else if (vr[i] !== 3'b000) begin
                n_errors++;
                $display("FAIL quiet_outputs inst%0d: got %b while out_valid=0, required 000", i, vr[i]);
            end
            prev_ov[i] = ov[i];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic tgt_t from_hex(input logic [63:0] h);
        tgt_t t;
        for (int i = 0; i < 16; i++) begin
            t[i] = int'(h[63-4*i -: 4]);
        end
        return t;
    endfunction

    // Independent reference: greedy dispatch with a SV queue as the siding.
    function automatic logic [2:0] ref_model(input int n, input bit m, input tgt_t t, input int depth);
        int st[$];
        int next_car = 1;
        int idx = 0;
        int head;
        for (int guard = 0; guard < 64; guard++) begin
            if (idx == n) return V_PASS;
            head = -1;
            if (st.size() > 0) head = m ? st[0] : st[st.size()-1];
            if (head == t[idx]) begin
                if (m) void'(st.pop_front());
                else void'(st.pop_back());
                idx++;
            end else if (next_car <= n) begin
                if (st.size() == depth) return V_OVF;
                st.push_back(next_car);
                next_car++;
            end else begin
                return V_MIS;
            end
        end
        return 3'b111;
    endfunction

    task automatic drive_seq(input int n, input bit m, input int nb, input tgt_t t);
        @(posedge clk); #1;
        in_valid = 1'b1;
        data = W'(n);
        mode = m;
        for (int i = 0; i < nb; i++) begin
            @(posedge clk); #1;
            data = W'(t[i]);
            mode = ~m;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        data = '0;
        mode = 1'b0;
    endtask

    // Push expectations, drive, then measure depth-10 latency and wait for every verdict.
    task automatic run_seq(input int n, input bit m, input int nb, input tgt_t t,
                           input logic [2:0] e0, input logic [2:0] e2, input logic [2:0] e4,
                           output int lat, output bit ok);
        bit got = 0;
        bit drained = 0;
        sq[0].push_back(e0);
        sq[1].push_back(e2);
        sq[2].push_back(e4);
        drive_seq(n, m, nb, t);
        lat = 0;
        repeat (2*MAXC + 8) begin
            @(negedge clk);
            if (ov0) begin
                got = 1;
                break;
            end
            lat++;
        end
        repeat (2*MAXC + 8) begin
            if (sq[0].size() == 0 && sq[1].size() == 0 && sq[2].size() == 0) begin
                drained = 1;
                break;
            end
            @(negedge clk);
        end
        if (!drained) begin
            for (int i = 0; i < 3; i++) sq[i].delete();
        end
        ok = got && drained;
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({ov0, res0, err0} !== 4'b0) begin
                n_errors++;
                $display("FAIL reset_outputs_d10: got %b, required 0000", {ov0, res0, err0});
            end
            n_checks++;
            if ({ov2, res2, err2, ov4, res4, err4} !== 8'b0) begin
                n_errors++;
                $display("FAIL reset_outputs_d2_d4: got %b, required 00000000", {ov2, res2, err2, ov4, res4, err4});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_lifo();
        int lat; bit ok;
        run_seq(5, 0, 5, from_hex(64'h3215_4000_0000_0000), V_PASS, V_OVF, V_PASS, lat, ok);
        n_checks++;
        if (!ok || lat > 12) begin
            n_errors++;
            $display("FAIL lifo_32154_timing: latency %0d ok %0b, required <= 12 and ok", lat, ok);
        end
        run_seq(5, 0, 5, from_hex(64'h3124_5000_0000_0000), V_MIS, V_OVF, V_MIS, lat, ok);
        n_checks++;
        if (!ok || lat > 12) begin
            n_errors++;
            $display("FAIL lifo_31245_timing: latency %0d ok %0b, required <= 12 and ok", lat, ok);
        end
    endtask

    task automatic test_depth();
        int lat; bit ok;
        run_seq(4, 0, 4, from_hex(64'h4321_0000_0000_0000), V_PASS, V_OVF, V_PASS, lat, ok);
        n_checks++;
        if (!ok || lat > 10) begin
            n_errors++;
            $display("FAIL depth_4321_timing: latency %0d ok %0b, required <= 10 and ok", lat, ok);
        end
    endtask

    task automatic test_fifo();
        int lat; bit ok;
        run_seq(4, 1, 4, from_hex(64'h1234_0000_0000_0000), V_PASS, V_PASS, V_PASS, lat, ok);
        n_checks++;
        if (!ok || lat > 10) begin
            n_errors++;
            $display("FAIL fifo_1234_timing: latency %0d ok %0b, required <= 10 and ok", lat, ok);
        end
        run_seq(4, 1, 4, from_hex(64'h2134_0000_0000_0000), V_MIS, V_OVF, V_MIS, lat, ok);
        n_checks++;
        if (!ok || lat > 10) begin
            n_errors++;
            $display("FAIL fifo_2134_timing: latency %0d ok %0b, required <= 10 and ok", lat, ok);
        end
    endtask

    task automatic test_bad_input();
        int ns [5] = '{3, 0, 3, 11, 3};
        int nbs [5] = '{2, 0, 3, 11, 3};
        logic [63:0] hs [5] = '{64'h1200_0000_0000_0000, 64'h0, 64'h1720_0000_0000_0000,
                                64'h1234_5678_9AB0_0000, 64'h1230_0000_0000_0000};
        logic [2:0] e;
        int lat; bit ok;
        for (int i = 0; i < 5; i++) begin
            e = (i == 4) ? V_PASS : V_BAD;
            run_seq(ns[i], 0, nbs[i], from_hex(hs[i]), e, e, e, lat, ok);
            n_checks++;
            if (!ok || (i != 4 && lat > 2)) begin
                n_errors++;
                $display("FAIL bad_input_%0d_timing: latency %0d ok %0b, required <= 2 and ok", i, lat, ok);
            end
        end
    endtask

    task automatic test_max_cars();
        int lat; bit ok;
        run_seq(10, 0, 10, from_hex(64'hA987_6543_2100_0000), V_PASS, V_OVF, V_OVF, lat, ok);
        n_checks++;
        if (!ok || lat > 22) begin
            n_errors++;
            $display("FAIL max_cars_timing: latency %0d ok %0b, required <= 22 and ok", lat, ok);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit ok;
        run_seq(1, 0, 1, from_hex(64'h1000_0000_0000_0000), V_PASS, V_PASS, V_PASS, lat, ok);
        n_checks++;
        if (!ok || lat > 4) begin
            n_errors++;
            $display("FAIL single_car_timing: latency %0d ok %0b, required <= 4 and ok", lat, ok);
        end
        run_seq(3, 1, 3, from_hex(64'h1230_0000_0000_0000), V_PASS, V_PASS, V_PASS, lat, ok);
        n_checks++;
        if (!ok || lat > 8) begin
            n_errors++;
            $display("FAIL back_to_back_timing: latency %0d ok %0b, required <= 8 and ok", lat, ok);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen = 0;
        int lat; bit ok;
        drive_seq(10, 0, 10, from_hex(64'h1234_5678_9A00_0000));
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (ov0 || ov2 || ov4) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL reset_mid_run_silent: got %0d verdict cycles, required 0", seen);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; data = 4'd3;
        @(posedge clk); #1 data = 4'd1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; data = '0; rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov0 || ov2 || ov4) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL reset_mid_load_silent: got %0d verdict cycles, required 0", seen);
        end
        run_seq(1, 0, 1, from_hex(64'h1000_0000_0000_0000), V_PASS, V_PASS, V_PASS, lat, ok);
        n_checks++;
        if (!ok || lat > 4) begin
            n_errors++;
            $display("FAIL after_reset_timing: latency %0d ok %0b, required <= 4 and ok", lat, ok);
        end
    endtask

    task automatic test_random();
        tgt_t t;
        int n, j, tmp, lat;
        bit m, ok;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, MAXC);
            m = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) t[i] = i + 1;
            for (int i = n - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = t[i]; t[i] = t[j]; t[j] = tmp;
            end
            run_seq(n, m, n, t, ref_model(n, m, t, 10), ref_model(n, m, t, 2),
                    ref_model(n, m, t, 4), lat, ok);
            n_checks++;
            if (!ok || lat > 2*n + 2) begin
                n_errors++;
                $display("FAIL random_%0d_timing: n %0d latency %0d ok %0b, required <= %0d and ok",
                         it, n, lat, ok, 2*n + 2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) prev_ov[i] = 1'b0;
        test_reset();
        test_lifo();
        test_depth();
        test_fifo();
        test_bad_input();
        test_max_cars();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
